wb_arbiter: RTL



---
 rtl/wb_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: drives the single integer register-file write port.
// Results from the single-cycle ALU path are queued in a small FIFO. Results
// from the multi-cycle load unit are taken directly. A one-write-per-cycle
// arbiter picks a winner, and the winner is registered onto
// addrDest/dataDest/weDest.
// A 32-bit scoreboard tracks registers with outstanding loads, so decode can
// stall on read-after-write hazards.
module wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            ld_valid,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    output logic            ld_ready,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic [4:0]      chkA_addr,
    input  logic [4:0]      chkB_addr,
    output logic            chkA_busy,
    output logic            chkB_busy,
    output logic [4:0]      addrDest,
    output logic [XLEN-1:0] dataDest,
    output logic            weDest
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] STARVE_C = SW'(STARVE_LIMIT);

    // ALU result FIFO storage and bookkeeping
    logic [4:0]      rd_mem_r   [FIFO_DEPTH];
    logic [XLEN-1:0] data_mem_r [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic [SW-1:0]   starve_cnt_r;
    logic [31:0]     sb_r;
    logic            we_ld_r;

    logic            empty_s;
    logic            full_s;
    logic            starve_hit_s;
    logic            push_s;
    logic            pop_s;
    logic            ld_win_s;
    logic            alu_win_s;
    logic [4:0]      head_rd_s;
    logic [XLEN-1:0] head_data_s;
    logic [31:0]     sb_set_s;
    logic [31:0]     sb_clr_s;
    logic [31:0]     sb_next_s;

    assign empty_s      = (count_r == CW'(0));
    assign full_s       = (count_r == DEPTH_C);
    assign starve_hit_s = !empty_s && (starve_cnt_r == STARVE_C);
    assign head_rd_s    = rd_mem_r[rd_ptr_r];
    assign head_data_s  = data_mem_r[rd_ptr_r];

    // Handshake outputs are held low while reset is asserted
    assign alu_ready = !rst && !full_s;
    assign ld_ready  = !rst && !starve_hit_s;
    assign push_s    = alu_valid && alu_ready;

    // Pick the single writer for this cycle: the load, unless the FIFO head is starved
    always_comb begin
        ld_win_s  = 1'b0;
        alu_win_s = 1'b0;
        if (ld_valid && !starve_hit_s) begin
            ld_win_s  = 1'b1;
            alu_win_s = 1'b0;
        end else if (!empty_s) begin
            ld_win_s  = 1'b0;
            alu_win_s = 1'b1;
        end else begin
            ld_win_s  = 1'b0;
            alu_win_s = 1'b0;
        end
    end

    assign pop_s = alu_win_s;

    // FIFO payload write; contents are discarded logically through the pointer reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            rd_mem_r[wr_ptr_r]   <= alu_rd;
            data_mem_r[wr_ptr_r] <= alu_data;
        end
    end

    // FIFO pointers and occupancy; a push and a pop in the same cycle leave the count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Count consecutive load wins over a waiting FIFO head, saturating at the limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_r <= SW'(0);
        end else if (empty_s || pop_s) begin
            starve_cnt_r <= SW'(0);
        end else if (ld_win_s && (starve_cnt_r != STARVE_C)) begin
            starve_cnt_r <= starve_cnt_r + SW'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // Register the winner onto the write port; x0 winners are consumed without a write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addrDest <= 5'd0;
            dataDest <= '0;
            weDest   <= 1'b0;
            we_ld_r  <= 1'b0;
        end else if (ld_win_s) begin
            addrDest <= ld_rd;
            dataDest <= ld_data;
            weDest   <= (ld_rd != 5'd0);
            we_ld_r  <= 1'b1;
        end else if (alu_win_s) begin
            addrDest <= head_rd_s;
            dataDest <= head_data_s;
            weDest   <= (head_rd_s != 5'd0);
            we_ld_r  <= 1'b0;
        end else begin
            weDest   <= 1'b0;
            we_ld_r  <= 1'b0;
        end
    end

    // Scoreboard update: a set from an issuing load overrides a clear from a completing load
    assign sb_set_s  = (issue_valid && (issue_rd != 5'd0)) ? (32'd1 << issue_rd) : 32'd0;
    assign sb_clr_s  = (weDest && we_ld_r) ? (32'd1 << addrDest) : 32'd0;
    assign sb_next_s = ((sb_r & ~sb_clr_s) | sb_set_s) & ~32'd1;

    // Scoreboard register; bit 0 is held at zero by the next-state mask
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_r <= 32'd0;
        end else begin
            sb_r <= sb_next_s;
        end
    end

    // Busy lookups read only the registered scoreboard, with no same-cycle issue bypass
    assign chkA_busy = sb_r[chkA_addr];
    assign chkB_busy = sb_r[chkB_addr];

endmodule
